// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60Hz VGA raster timing generator with registered sync/blank/RGB stage
//
// Purpose:
//   A clock divider produces a pixel strobe. On each strobe the column/row
//   raster counters advance. The graphics drivers see the counters on
//   VGA_row/VGA_col and return input_color combinationally. On the same
//   strobe the output stage registers sync, blank and RGB. These outputs are
//   computed from the pre-advance counters and the returned colour, so every
//   pin lags its counter value by exactly one pixel period.
//   Per-frame strobes (frame_start, vblank_start) coincide with the pixel
//   strobe that causes the corresponding counter transition.
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   When defined, the design adds an 8-bit frame_count and a 1-bit
//   frame_toggle. Both advance on every frame_start.
//   When undefined, neither port nor its logic exists.
//
// Ports:
//   clk           in   1   system clock
//   rst_l         in   1   asynchronous active-low reset
//   input_color   in  24   {R,G,B} for the current VGA_row/VGA_col
//   VGA_row       out 10   line counter, 0..V_TOTAL-1
//   VGA_col       out 10   pixel counter, 0..H_TOTAL-1
//   pixel_en      out  1   strobe on the clk whose edge advances the counters
//   VGA_HS        out  1   horizontal sync, active low
//   VGA_VS        out  1   vertical sync, active low
//   VGA_BLANK_N   out  1   high while the output pixel is visible
//   VGA_R/G/B     out  8   colour to the DAC, zero outside the visible area
//   frame_start   out  1   pulse with the strobe that wraps to (0,0)
//   vblank_start  out  1   pulse with the strobe that moves row to V_VISIBLE
//   frame_count   out  8   (VGA_FRAME_COUNT_EN) frames since reset, wraps
//   frame_toggle  out  1   (VGA_FRAME_COUNT_EN) inverts every frame

module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [23:0] input_color,
  output logic [9:0]  VGA_row,
  output logic [9:0]  VGA_col,
  output logic        pixel_en,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start,
  output logic        vblank_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frame_count,
  output logic        frame_toggle
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // A one-cycle divider still needs a 1-bit register, which simply stays 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_col;
  logic [9:0]       r_row;
  logic             r_hs_n;
  logic             r_vs_n;
  logic             r_blank_n;
  logic [7:0]       r_red;
  logic [7:0]       r_grn;
  logic [7:0]       r_blu;

  logic w_tick;
  logic w_pix_en;
  logic w_col_last;
  logic w_row_last;
  logic w_visible;
  logic w_hs_active;
  logic w_vs_active;

  assign w_tick = (r_div == DIV_LAST);

  // The rst_l gate matters only for CLK_DIV=1. In that case the divider is
  // permanently at its last value, so the strobe would otherwise stay high
  // during reset.
  assign w_pix_en = w_tick & rst_l;

  assign w_col_last = (r_col == H_LAST);
  assign w_row_last = (r_row == V_LAST);

  // Output decode uses the counters before they advance. A pixel's timing
  // and colour therefore leave the chip one pixel period after its counter
  // value was presented.
  assign w_visible   = (r_col < H_VIS_END) && (r_row < V_VIS_END);
  assign w_hs_active = (r_col >= H_SYNC_START) && (r_col < H_SYNC_END);
  assign w_vs_active = (r_row >= V_SYNC_START) && (r_row < V_SYNC_END);

  // Pixel clock divider: counts 0..CLK_DIV-1 and strobes on the last count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_col <= 10'd0;
      r_row <= 10'd0;
    end else if (w_tick) begin
      if (w_col_last) begin
        r_col <= 10'd0;
        if (w_row_last) begin
          r_row <= 10'd0;
        end else begin
          r_row <= r_row + 10'd1;
        end
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  // Output stage. Sync, blank and colour load together so they can never
  // skew relative to each other at the DAC.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= 8'h00;
      r_grn     <= 8'h00;
      r_blu     <= 8'h00;
    end else if (w_tick) begin
      r_hs_n    <= ~w_hs_active;
      r_vs_n    <= ~w_vs_active;
      r_blank_n <= w_visible;
      r_red     <= w_visible ? input_color[23:16] : 8'h00;
      r_grn     <= w_visible ? input_color[15:8]  : 8'h00;
      r_blu     <= w_visible ? input_color[7:0]   : 8'h00;
    end
  end

  assign VGA_row      = r_row;
  assign VGA_col      = r_col;
  assign pixel_en     = w_pix_en;
  assign VGA_HS       = r_hs_n;
  assign VGA_VS       = r_vs_n;
  assign VGA_BLANK_N  = r_blank_n;
  assign VGA_R        = r_red;
  assign VGA_G        = r_grn;
  assign VGA_B        = r_blu;

  // Both frame strobes are qualified by the pixel strobe. Each one is
  // therefore exactly one clk wide and appears once per frame.
  assign frame_start  = w_pix_en & w_col_last & w_row_last;
  assign vblank_start = w_pix_en & w_col_last & (r_row == V_VIS_LAST);

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;
  logic       r_frame_toggle;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_frame_count  <= 8'd0;
      r_frame_toggle <= 1'b0;
    end else if (frame_start) begin
      r_frame_count  <= r_frame_count + 8'd1;
      r_frame_toggle <= ~r_frame_toggle;
    end
  end

  assign frame_count  = r_frame_count;
  assign frame_toggle = r_frame_toggle;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster

module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int H_VIS   = 6;
  localparam int H_FP    = 2;
  localparam int H_SYN   = 3;
  localparam int H_BP    = 2;
  localparam int V_VIS   = 4;
  localparam int V_FP    = 1;
  localparam int V_SYN   = 2;
  localparam int V_BP    = 1;
  localparam int H_TOT   = H_VIS + H_FP + H_SYN + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYN + V_BP;
  localparam int FRAME_CLKS = H_TOT * V_TOT * CLK_DIV;
  localparam logic [26:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 24'h000000};

  logic        clk;
  logic        rst_l;
  logic [23:0] input_color;
  logic [9:0]  VGA_row;
  logic [9:0]  VGA_col;
  logic        pixel_en;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        frame_start;
  logic        vblank_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]  frame_count;
  logic        frame_toggle;
`endif

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .input_color(input_color),
    .VGA_row(VGA_row),
    .VGA_col(VGA_col),
    .pixel_en(pixel_en),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B),
    .frame_start(frame_start),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(frame_count),
    .frame_toggle(frame_toggle),
`endif
    .vblank_start(vblank_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, as seen at the current falling edge.
  int          m_div;
  int          m_row;
  int          m_col;
  logic [7:0]  m_fc;
  logic        m_ft;
  logic [26:0] q_out[$];
  int          q_col[$];
  logic [26:0] cur;
  int          cur_col;
  logic        rand_col;
  logic        seen_255;

  int n_vis, n_hs, n_vs, n_fs, n_vb, first_hs_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] exp_out(input int r, input int c, input logic [23:0] color);
    logic vis;
    logic hs_n;
    logic vs_n;
    vis  = (c < H_VIS) && (r < V_VIS);
    hs_n = !((c >= H_VIS + H_FP) && (c < H_VIS + H_FP + H_SYN));
    vs_n = !((r >= V_VIS + V_FP) && (r < V_VIS + V_FP + V_SYN));
    return {hs_n, vs_n, vis, vis ? color : 24'h000000};
  endfunction

  task automatic clear_stats();
    n_vis = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_vb = 0;
  endtask

  task automatic step();
    logic exp_pen;
    logic exp_fs;
    logic exp_vb;
    logic popped;
    popped = 1'b0;
    @(negedge clk);
    // Apply the rising edge that just happened.
    if (m_div == CLK_DIV - 1) begin
      if (m_col == H_TOT - 1) begin
        m_col = 0;
        if (m_row == V_TOT - 1) begin
          m_row = 0;
          m_fc  = m_fc + 8'd1;
          m_ft  = ~m_ft;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
      m_div = 0;
      if (q_out.size() > 0) begin
        cur     = q_out.pop_front();
        cur_col = q_col.pop_front();
        popped  = 1'b1;
      end
    end else begin
      m_div++;
    end

    exp_pen = (m_div == CLK_DIV - 1);
    exp_fs  = exp_pen && (m_row == V_TOT - 1) && (m_col == H_TOT - 1);
    exp_vb  = exp_pen && (m_row == V_VIS - 1) && (m_col == H_TOT - 1);

    check("out", {5'b0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {5'b0, cur});
    check("pixel_en", 32'(pixel_en), 32'(exp_pen));
    check("row", 32'(VGA_row), 32'(m_row));
    check("col", 32'(VGA_col), 32'(m_col));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("vblank_start", 32'(vblank_start), 32'(exp_vb));
`ifdef VGA_FRAME_COUNT_EN
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("frame_toggle", 32'(frame_toggle), 32'(m_ft));
    if (frame_count == 8'd255) seen_255 = 1'b1;
`endif

    if (popped) begin
      if (VGA_BLANK_N) n_vis++;
      if (!VGA_VS) n_vs++;
      if (!VGA_HS) begin
        n_hs++;
        if (first_hs_col < 0) first_hs_col = cur_col;
      end
    end
    if (frame_start) n_fs++;
    if (vblank_start) n_vb++;

    // Colour is only meaningful on the strobe cycle; junk elsewhere must be ignored.
    if (exp_pen) begin
      input_color = rand_col ? 24'($urandom) : 24'hFF8001;
      q_out.push_back(exp_out(m_row, m_col, input_color));
      q_col.push_back(m_col);
    end else begin
      input_color = 24'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    #2;
    check("rst_out", {5'b0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {5'b0, RESET_OUT});
    check("rst_pixel_en", 32'(pixel_en), 32'd0);
    check("rst_row", 32'(VGA_row), 32'd0);
    check("rst_col", 32'(VGA_col), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_vblank_start", 32'(vblank_start), 32'd0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    m_div = 0; m_row = 0; m_col = 0;
    m_fc = 8'd0; m_ft = 1'b0;
    q_out.delete();
    q_col.delete();
    cur = RESET_OUT;
    cur_col = 0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_visible"}, 32'(n_vis), 32'(H_VIS * V_VIS));
    check({tag, "_hs_low"}, 32'(n_hs), 32'(H_SYN * V_TOT));
    check({tag, "_vs_low"}, 32'(n_vs), 32'(V_SYN * H_TOT));
    check({tag, "_frame_start"}, 32'(n_fs), 32'd1);
    check({tag, "_vblank_start"}, 32'(n_vb), 32'd1);
    clear_stats();
  endtask

  initial begin
    logic found;
    rst_l = 1'b0;
    input_color = 24'h000000;
    rand_col = 1'b0;
    seen_255 = 1'b0;
    first_hs_col = -1;
    clear_stats();
    repeat (2) @(negedge clk);
    do_reset();

    // Frame 1: constant colour, timing counts and first sync column.
    repeat (FRAME_CLKS) step();
    check("first_hs_col", 32'(first_hs_col), 32'(H_VIS + H_FP));
    check_frame("f1");

    // Frame 2: random colour per pixel.
    rand_col = 1'b1;
    repeat (FRAME_CLKS) step();
    check_frame("f2");

    // Mid-frame reset inside the visible region.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      step();
      if (m_row == 2 && m_col == 4) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_reset_point", 32'(found), 32'd1);
    do_reset();
    clear_stats();
    repeat (FRAME_CLKS) step();
    check_frame("f3");

`ifdef VGA_FRAME_COUNT_EN
    repeat (255 * FRAME_CLKS) step();
    check("frame_count_wrap", 32'(frame_count), 32'd0);
    check("frame_count_seen_255", 32'(seen_255), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
